// File: rtl/irq_controller_n.sv
// Interrupt controller for the 65C02 bus: N_IRQ active-low sources.
// Optional macro IRQ_SYNC_EN adds a 2-flop input synchroniser.
module irq_controller_n #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             resb,
  input  logic [7:0]       i_data,
  output logic [7:0]       o_data,
  input  logic             cs,
  input  logic             rwb,
  input  logic [2:0]       addr,
  input  logic [N_IRQ-1:0] irqb,
  output logic             irqb_master
);

  // Channels beyond N_IRQ are forced inactive so every bank
  // window can be sliced out of a uniform 32-bit vector.
  localparam logic [31:0] MASK =
    32'((64'd1 << N_IRQ) - 64'd1);

  logic [31:0] w_pin;
  logic [31:0] w_s;
  logic [31:0] r_irqb_d;
  logic [31:0] r_enable;
  logic [31:0] r_mode;
  logic [31:0] r_pend;
  logic [31:0] w_pend;
  logic [31:0] w_act;
  logic [31:0] w_raw;
  logic [31:0] w_set;
  logic [31:0] w_en_wr;
  logic [31:0] w_md_wr;
  logic [31:0] w_w1c;
  logic [31:0] w_eoi;
  logic [31:0] w_clr;
  logic [1:0]  r_bank;
  logic        r_gen;
  logic        r_master;
  logic        w_wr;
  logic [4:0]  w_base;
  logic [7:0]  w_vec;

  assign w_pin = ~MASK | 32'(irqb);

`ifdef IRQ_SYNC_EN
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;

  // two-stage synchroniser on the request pins
  always_ff @(posedge clk) begin
    if (!resb) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = w_pin;
`endif

  assign w_wr   = cs & ~rwb;
  assign w_base = {r_bank, 3'b000};
  assign w_set  = r_irqb_d & ~w_s;
  assign w_raw  = ~w_s;
  assign w_pend = (r_mode & r_pend)
                | (~r_mode & ~w_s);
  assign w_act  = w_pend & r_enable;
  assign w_clr  = w_w1c | w_eoi;

  // merge CPU writes into the banked channel vectors
  always_comb begin
    w_en_wr = r_enable;
    w_md_wr = r_mode;
    w_w1c   = '0;
    w_eoi   = '0;
    if (w_wr && addr == 3'd2)
      w_en_wr[w_base +: 8] = i_data;
    if (w_wr && addr == 3'd3)
      w_md_wr[w_base +: 8] = i_data;
    if (w_wr && addr == 3'd4)
      w_w1c[w_base +: 8] = i_data;
    if (w_wr && addr == 3'd0)
      w_eoi = 32'd1 << i_data[4:0];
  end

  // previous sample for edge detect, reloaded even in reset
  always_ff @(posedge clk) begin
    r_irqb_d <= w_s;
  end

  // control registers, edge-latched pending and master output
  always_ff @(posedge clk) begin
    if (!resb) begin
      r_enable <= '0;
      r_mode   <= '0;
      r_pend   <= '0;
      r_bank   <= '0;
      r_gen    <= 1'b0;
      r_master <= 1'b1;
    end else begin
      r_enable <= w_en_wr & MASK;
      r_mode   <= w_md_wr & MASK;
      r_pend   <= w_md_wr & r_mode & MASK
                & (w_set | (r_pend & ~w_clr));
      if (w_wr && addr == 3'd1)
        r_bank <= i_data[1:0];
      if (w_wr && addr == 3'd6)
        r_gen <= i_data[0];
      r_master <= ~(r_gen & (|w_act));
    end
  end

  assign irqb_master = r_master;

  // lowest-index active channel wins the vector
  always_comb begin
    w_vec = 8'h80;
    for (int i = 31; i >= 0; i--) begin
      if (w_act[i])
        w_vec = {1'b0, 7'(i)};
    end
  end

  // register read mux
  always_comb begin
    o_data = 8'h00;
    case (addr)
      3'd0: o_data = w_vec;
      3'd1: o_data = {6'b0, r_bank};
      3'd2: o_data = r_enable[w_base +: 8];
      3'd3: o_data = r_mode[w_base +: 8];
      3'd4: o_data = w_pend[w_base +: 8];
      3'd5: o_data = w_raw[w_base +: 8];
      3'd6: o_data = {7'b0, r_gen};
      default: o_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_controller_n.sv
// Randomised bench for irq_controller_n with a
// channel-level reference model (default build).
`timescale 1ns/1ps
module tb_irq_controller_n;

  localparam int N = 20;

  logic         clk;
  logic         resb;
  logic [7:0]   i_data;
  logic [7:0]   o_data;
  logic         cs;
  logic         rwb;
  logic [2:0]   addr;
  logic [N-1:0] irqb;
  logic         irqb_master;

  int n_vec;
  int n_err;

  bit en [32];
  bit md [32];
  bit pe [32];
  bit dd [32];
  bit mgen;
  int mbank;
  bit mmst;

  irq_controller_n #(.N_IRQ(N)) dut (
    .clk         (clk),
    .resb        (resb),
    .i_data      (i_data),
    .o_data      (o_data),
    .cs          (cs),
    .rwb         (rwb),
    .addr        (addr),
    .irqb        (irqb),
    .irqb_master (irqb_master)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit eff(input int i,
                             input logic [N-1:0] irq);
    return md[i] ? pe[i] : !irq[i];
  endfunction

  function automatic logic [7:0] mread(
    input int a, input logic [N-1:0] irq);
    logic [7:0] r;
    int ch;
    r = 8'h00;
    case (a)
      0: begin
        r = 8'h80;
        for (int i = N - 1; i >= 0; i--)
          if (eff(i, irq) && en[i]) r = 8'(i);
      end
      1: r = 8'(mbank);
      2, 3, 4, 5: begin
        for (int b = 0; b < 8; b++) begin
          ch = mbank * 8 + b;
          if (ch < N) begin
            case (a)
              2: r[b] = en[ch];
              3: r[b] = md[ch];
              4: r[b] = eff(ch, irq);
              default: r[b] = !irq[ch];
            endcase
          end
        end
      end
      6: r = {7'b0, mgen};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic mupd(input logic rb, input logic c,
                      input logic r, input logic [2:0] a,
                      input logic [7:0] dt,
                      input logic [N-1:0] irq);
    bit clr [32];
    bit mdn [32];
    bit any;
    bit newm;
    bit wr;
    int ch;
    if (!rb) begin
      for (int i = 0; i < 32; i++) begin
        en[i] = 0; md[i] = 0; pe[i] = 0;
        dd[i] = (i < N) ? irq[i] : 1'b1;
      end
      mgen = 0;
      mbank = 0;
      mmst = 1;
      return;
    end
    any = 0;
    for (int i = 0; i < N; i++)
      if (eff(i, irq) && en[i]) any = 1;
    newm = !(mgen && any);
    for (int i = 0; i < 32; i++) begin
      clr[i] = 0;
      mdn[i] = md[i];
    end
    wr = c && !r;
    if (wr && a == 3'd0 && int'(dt[4:0]) < N)
      clr[dt[4:0]] = 1;
    for (int b = 0; b < 8; b++) begin
      ch = mbank * 8 + b;
      if (wr && ch < N) begin
        if (a == 3'd4 && dt[b]) clr[ch] = 1;
        if (a == 3'd3) mdn[ch] = dt[b];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!mdn[i] || !md[i]) pe[i] = 0;
      else pe[i] = (dd[i] && !irq[i])
                 || (pe[i] && !clr[i]);
    end
    for (int b = 0; b < 8; b++) begin
      ch = mbank * 8 + b;
      if (wr && a == 3'd2 && ch < N) en[ch] = dt[b];
    end
    for (int i = 0; i < N; i++) begin
      md[i] = mdn[i];
      dd[i] = irq[i];
    end
    if (wr && a == 3'd6) mgen = dt[0];
    if (wr && a == 3'd1) mbank = int'(dt[1:0]);
    mmst = newm;
  endtask

  task automatic cyc(input logic rb, input logic c,
                     input logic r, input logic [2:0] a,
                     input logic [7:0] dt,
                     input logic [N-1:0] irq);
    resb   = rb;
    cs     = c;
    rwb    = r;
    addr   = a;
    i_data = dt;
    irqb   = irq;
    @(posedge clk);
    mupd(rb, c, r, a, dt, irq);
    #1;
    chk("master", {7'b0, irqb_master}, {7'b0, mmst});
    cs  = 1'b1;
    rwb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr = 3'(k);
      #1;
      chk($sformatf("rd%0d", k), o_data, mread(k, irq));
    end
    cs = 1'b0;
  endtask

  logic [N-1:0] hi;
  logic [N-1:0] p;
  logic [N-1:0] cur;
  logic [N-1:0] fl;

  initial begin
    n_vec = 0;
    n_err = 0;
    hi = '1;
    resb = 1'b0; cs = 1'b0; rwb = 1'b1;
    addr = 3'd0; i_data = 8'h00; irqb = '0;

    cyc(0, 0, 1, 3'd0, 8'h00, '0);
    cyc(0, 0, 1, 3'd0, 8'h00, '0);
    cyc(1, 0, 1, 3'd0, 8'h00, '0);
    cyc(1, 0, 1, 3'd0, 8'h00, hi);

    cyc(1, 1, 0, 3'd3, 8'h04, hi);
    cyc(1, 1, 0, 3'd2, 8'h04, hi);
    cyc(1, 1, 0, 3'd6, 8'h01, hi);
    p = hi; p[2] = 1'b0;
    cyc(1, 0, 1, 3'd0, 8'h00, p);
    cyc(1, 0, 1, 3'd0, 8'h00, hi);
    cyc(1, 0, 1, 3'd0, 8'h00, hi);
    cyc(1, 1, 0, 3'd0, 8'h02, hi);
    cyc(1, 0, 1, 3'd0, 8'h00, hi);

    cyc(1, 1, 0, 3'd3, 8'h00, hi);
    cyc(1, 1, 0, 3'd2, 8'h22, hi);
    p = hi; p[1] = 1'b0; p[5] = 1'b0;
    cyc(1, 0, 1, 3'd0, 8'h00, p);
    p[1] = 1'b1;
    cyc(1, 0, 1, 3'd0, 8'h00, p);
    cyc(1, 0, 1, 3'd0, 8'h00, hi);

    cyc(1, 1, 0, 3'd1, 8'h02, hi);
    cyc(1, 1, 0, 3'd2, 8'hFF, hi);
    cyc(1, 1, 0, 3'd3, 8'hFF, hi);
    p = hi; p[19] = 1'b0;
    cyc(1, 0, 1, 3'd0, 8'h00, p);
    cyc(1, 0, 1, 3'd0, 8'h00, hi);
    cyc(1, 1, 0, 3'd1, 8'h03, hi);
    cyc(1, 1, 0, 3'd2, 8'hFF, hi);
    cyc(1, 1, 0, 3'd1, 8'h02, hi);
    cyc(1, 1, 0, 3'd0, 8'h13, hi);

    cyc(1, 1, 0, 3'd1, 8'h00, hi);
    cyc(1, 1, 0, 3'd3, 8'h01, hi);
    cyc(1, 1, 0, 3'd2, 8'h01, hi);
    p = hi; p[0] = 1'b0;
    cyc(1, 0, 1, 3'd0, 8'h00, p);
    cyc(1, 0, 1, 3'd0, 8'h00, hi);
    cyc(1, 1, 0, 3'd4, 8'h01, p);
    cyc(1, 0, 1, 3'd0, 8'h00, p);

    cyc(1, 1, 0, 3'd6, 8'h00, p);
    cyc(1, 0, 1, 3'd0, 8'h00, p);
    cyc(1, 1, 0, 3'd6, 8'h01, p);
    cyc(1, 0, 1, 3'd0, 8'h00, p);

    cur = hi;
    for (int n = 0; n < 1500; n++) begin
      fl  = N'($urandom & $urandom & $urandom);
      cur = cur ^ fl;
      cyc(($urandom_range(0, 99) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0),
          3'($urandom_range(0, 7)),
          8'($urandom),
          cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
